// File: rtl/bitslice_sort_ctrl.sv
// Comparator-free sorter control: loads a batch into the unsorted-element memory and emits it in signed order
// by narrowing a candidate mask over bit columns, MSB first. Define DESCEND_EN for descending order.
module bitslice_sort_ctrl #(
    parameter int DATA_WIDTH       = 8,
    parameter int ELEMENT_NUM      = 16,
    parameter int LOG2_ELEMENT_NUM = 4,
    parameter int LOG2_DATA_WIDTH  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    output logic                        um_in_valid,
    output logic [DATA_WIDTH-1:0]       um_in_data,
    output logic [LOG2_ELEMENT_NUM-1:0] UM_addr,
    output logic [LOG2_DATA_WIDTH-1:0]  bit_addr,
    input  logic [ELEMENT_NUM-1:0]      bit_data,
    input  logic [DATA_WIDTH-1:0]       um_out_data,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [LOG2_ELEMENT_NUM-1:0] out_idx,
    output logic                        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_EMIT = 2'd3;

    localparam logic [ELEMENT_NUM-1:0]      ALL_ONES = {ELEMENT_NUM{1'b1}};
    localparam logic [ELEMENT_NUM-1:0]      ALL_ZERO = {ELEMENT_NUM{1'b0}};
    localparam logic [ELEMENT_NUM-1:0]      ONE_HOT0 = {{(ELEMENT_NUM-1){1'b0}}, 1'b1};
    localparam logic [LOG2_DATA_WIDTH-1:0]  TOP_BIT  = LOG2_DATA_WIDTH'(DATA_WIDTH - 1);
    localparam logic [LOG2_DATA_WIDTH-1:0]  BIT_ZERO = {LOG2_DATA_WIDTH{1'b0}};
    localparam logic [LOG2_ELEMENT_NUM-1:0] IDX_ZERO = {LOG2_ELEMENT_NUM{1'b0}};
    localparam logic [LOG2_ELEMENT_NUM-1:0] IDX_ONE  = LOG2_ELEMENT_NUM'(1);
    localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_IDX = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

    // Lowest set index of a mask; the lowest index wins so equal keys leave in UM order.
    function automatic logic [LOG2_ELEMENT_NUM-1:0] lowest_idx(input logic [ELEMENT_NUM-1:0] m);
        logic [LOG2_ELEMENT_NUM-1:0] r;
        r = IDX_ZERO;
        for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = LOG2_ELEMENT_NUM'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [1:0]                  state_r,     state_nxt_s;
    logic [LOG2_ELEMENT_NUM-1:0] count_r,     count_nxt_s;
    logic [ELEMENT_NUM-1:0]      used_r,      used_nxt_s;
    logic [ELEMENT_NUM-1:0]      cand_r,      cand_nxt_s;
    logic                        out_valid_r, out_valid_nxt_s;
    logic [DATA_WIDTH-1:0]       out_data_r,  out_data_nxt_s;
    logic [LOG2_ELEMENT_NUM-1:0] out_idx_r,   out_idx_nxt_s;
    logic                        done_r,      done_nxt_s;
    logic [LOG2_ELEMENT_NUM-1:0] um_addr_r,   um_addr_nxt_s;
    logic [LOG2_DATA_WIDTH-1:0]  bit_addr_r,  bit_addr_nxt_s;

    logic                        ready_s;
    logic                        accept_s;
    logic [ELEMENT_NUM-1:0]      zero_s;
    logic [ELEMENT_NUM-1:0]      cand_scan_s;
    logic [ELEMENT_NUM-1:0]      used_sel_s;

    assign ready_s     = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    assign accept_s    = in_valid & ready_s;
    assign in_ready    = ready_s;
    assign um_in_valid = accept_s;
    assign um_in_data  = in_data;
    assign UM_addr     = um_addr_r;
    assign bit_addr    = bit_addr_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_idx     = out_idx_r;
    assign done        = done_r;

    // Column filter: keep candidates whose (sign-corrected) bit is the preferred value, unless none have it.
`ifdef DESCEND_EN
    assign zero_s = cand_r & bit_data;
`else
    assign zero_s = cand_r & ~bit_data;
`endif
    assign cand_scan_s = (zero_s != ALL_ZERO) ? zero_s : cand_r;
    assign used_sel_s  = used_r | (ONE_HOT0 << um_addr_r);

    // Next-state logic; UM_addr is loaded with the winner on the final scan cycle so EMIT reads it directly.
    always_comb begin
        state_nxt_s     = state_r;
        count_nxt_s     = count_r;
        used_nxt_s      = used_r;
        cand_nxt_s      = cand_r;
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = out_data_r;
        out_idx_nxt_s   = out_idx_r;
        done_nxt_s      = 1'b0;
        um_addr_nxt_s   = um_addr_r;
        bit_addr_nxt_s  = bit_addr_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (accept_s) begin
                    used_nxt_s     = ALL_ZERO;
                    cand_nxt_s     = ALL_ONES;
                    bit_addr_nxt_s = TOP_BIT;
                    if (count_r == LAST_IDX) begin
                        state_nxt_s   = ST_SCAN;
                        count_nxt_s   = IDX_ZERO;
                        um_addr_nxt_s = IDX_ZERO;
                    end else begin
                        state_nxt_s   = ST_LOAD;
                        count_nxt_s   = count_r + IDX_ONE;
                        um_addr_nxt_s = count_r + IDX_ONE;
                    end
                end else begin
                    um_addr_nxt_s = count_r;
                end
            end
            ST_SCAN: begin
                cand_nxt_s = cand_scan_s;
                if (bit_addr_r == BIT_ZERO) begin
                    state_nxt_s   = ST_EMIT;
                    um_addr_nxt_s = lowest_idx(cand_scan_s);
                end else begin
                    bit_addr_nxt_s = bit_addr_r - LOG2_DATA_WIDTH'(1);
                end
            end
            ST_EMIT: begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = um_out_data;
                out_idx_nxt_s   = um_addr_r;
                used_nxt_s      = used_sel_s;
                if (used_sel_s == ALL_ONES) begin
                    done_nxt_s    = 1'b1;
                    state_nxt_s   = ST_IDLE;
                    count_nxt_s   = IDX_ZERO;
                    um_addr_nxt_s = IDX_ZERO;
                end else begin
                    cand_nxt_s     = ~used_sel_s;
                    bit_addr_nxt_s = TOP_BIT;
                    state_nxt_s    = ST_SCAN;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                count_nxt_s   = IDX_ZERO;
                um_addr_nxt_s = IDX_ZERO;
            end
        endcase
    end

    // State and output registers; reset aborts any batch in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            count_r     <= IDX_ZERO;
            used_r      <= ALL_ZERO;
            cand_r      <= ALL_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_idx_r   <= IDX_ZERO;
            done_r      <= 1'b0;
            um_addr_r   <= IDX_ZERO;
            bit_addr_r  <= BIT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            used_r      <= used_nxt_s;
            cand_r      <= cand_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_idx_r   <= out_idx_nxt_s;
            done_r      <= done_nxt_s;
            um_addr_r   <= um_addr_nxt_s;
            bit_addr_r  <= bit_addr_nxt_s;
        end
    end

endmodule

// File: doc/bitslice_sort_ctrl.md
Name: bitslice_sort_ctrl

Overview:
- Control stage directly downstream of the unsorted-element memory (UM); also sequences UM writes.
- Loads ELEMENT_NUM signed elements into UM, then sorts them without comparators: MSB-to-LSB scans of UM bit columns (bit_data) narrow a candidate mask.
- Emits elements one at a time in ascending signed order, reading each selected word back through UM out_data.

Parameters:
- DATA_WIDTH, 8: element width in bits, signed two's complement.
- ELEMENT_NUM, 16: elements per sort batch.
- LOG2_ELEMENT_NUM, 4: UM address width.
- LOG2_DATA_WIDTH, 3: bit-column address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input element beat.
- in_data  in  DATA_WIDTH  input element.
- in_ready  out  1  high in IDLE/LOAD.
- um_in_valid  out  1  UM write enable (in_valid & in_ready).
- um_in_data  out  DATA_WIDTH  UM write data (in_data passthrough).
- UM_addr  out  LOG2_ELEMENT_NUM  UM write/read address.
- bit_addr  out  LOG2_DATA_WIDTH  UM bit-column select.
- bit_data  in  ELEMENT_NUM  UM column; MSB column arrives already inverted by UM.
- um_out_data  in  DATA_WIDTH  UM word at UM_addr.
- out_valid  out  1  one-cycle pulse per sorted element.
- out_data  out  DATA_WIDTH  sorted element.
- out_idx  out  LOG2_ELEMENT_NUM  UM index of out_data.
- done  out  1  one-cycle pulse with the last out_valid.

Behaviour:
- Reset (rst=0): state=IDLE; load count, used mask, candidate mask, out_valid, out_data, out_idx, done, UM_addr and bit_addr all 0. A reset during any state aborts the batch. UM is reset separately by its owner.
- States: IDLE, LOAD, SCAN, EMIT.
- IDLE: on the first accepted beat, write it to UM at address 0 and go to LOAD.
- LOAD:
  - UM_addr = load count; each accepted beat writes and increments the count.
  - On the beat with count = ELEMENT_NUM-1, go to SCAN.
  - used = 0, candidate mask C = all ones, bit_addr = DATA_WIDTH-1.
- SCAN, one column per cycle, bit_addr from DATA_WIDTH-1 down to 0:
  - Z = C & ~bit_data. If Z != 0 then C <= Z, else C is unchanged.
  - After the bit_addr=0 cycle, go to EMIT.
  - Scan length is always DATA_WIDTH cycles (no early exit).
- EMIT (1 cycle):
  - sel = lowest set index of C, which gives a stable tie-break.
  - UM_addr = sel; out_data <= um_out_data; out_idx <= sel; out_valid <= 1 on the next cycle; used[sel] <= 1.
  - If all elements are now used: done <= 1 with that out_valid, then go to IDLE.
  - Otherwise: C <= ~(used | onehot(sel)), bit_addr <= DATA_WIDTH-1, go to SCAN.
- Latency: last load beat at cycle t → first out_valid at t+DATA_WIDTH+2. Output period is DATA_WIDTH+1 cycles. A full batch takes ELEMENT_NUM*(DATA_WIDTH+1) cycles after load.
- in_ready = 0 in SCAN/EMIT; in_valid is ignored there and produces no UM write.
- Gaps in in_valid during LOAD are allowed; the count only advances on accepted beats.
- C is never empty in SCAN because at least one element is unused.
- Duplicates are emitted in ascending UM index order.
- After done, a new batch may start the next cycle. It overwrites all UM entries.

Optional Feature:
- DESCEND_EN defined: descending signed order. SCAN uses Z = C & bit_data. Tie-break remains lowest index.
- DESCEND_EN undefined: ascending order as specified above.

Test Plan:
- Load {5,-3,0,127} (ELEMENT_NUM=4, DATA_WIDTH=8) → out_data 8'hFD,8'h00,8'h05,8'h7F; out_idx 1,2,0,3; done with the 4th pulse.
- Load {2,2,1,2} → out_data 1,2,2,2; out_idx 2,0,1,3 (stable ties).
- Load {-128,127,-1,0}, with in_valid gaps of 2 cycles between beats → -128,-1,0,127; first out_valid exactly 10 cycles after the last beat; pulses 9 cycles apart.
- in_valid held high during SCAN with in_data=8'h55 → in_ready=0, no um_in_valid, sorted output unchanged.
- Assert rst low mid-SCAN of the 2nd element → all outputs 0, state IDLE; a fresh batch {3,1,2,0} → 0,1,2,3.
- With DESCEND_EN: load {5,-3,0,127} → 127,5,0,-3.
